// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM encoding for the four-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned CODE_W = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_dec_2_4.sv
// Combinational 2-bit code to 4-bit one-hot decoder.
module onehot_dec_2_4
    import rr_arb_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [NREQ-1:0]   onehot_o
);

    always_comb begin
        onehot_o         = '0;
        onehot_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter; a grant is held until the owner releases it.
// Optional grant watchdog enabled by defining GRANT_TIMEOUT_EN.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic              done_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [CODE_W-1:0] gnt_code_o,
    output logic              gnt_vld_o,
    output logic              timeout_o
);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              vld_q, vld_d;
    logic              timeout_q, timeout_d;

    logic [NREQ-1:0]   req_rot;
    logic [CODE_W-1:0] first_off;
    logic [CODE_W-1:0] winner;
    logic              release_grant;
    logic              expire;
    logic [NREQ-1:0]   dec;

    // Rotate so the pointer position lands at bit 0, find first, then rotate back.
    always_comb begin
        logic [CODE_W-1:0] idx;
        logic              found;
        req_rot   = '0;
        first_off = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx        = CODE_W'(i) + ptr_q;
            req_rot[i] = req_i[idx];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found     = 1'b1;
                first_off = CODE_W'(i);
            end
        end
        winner = first_off + ptr_q;
    end

    assign release_grant = done_i || !req_i[code_q];

`ifdef GRANT_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == TO_W'(TIMEOUT - 1));
    assign cnt_d  = (state_q == StIdle) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = ^{TIMEOUT, TO_W};
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        code_d    = code_q;
        vld_d     = vld_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d = StGrant;
                    code_d  = winner;
                    vld_d   = 1'b1;
                    ptr_d   = winner + 1'b1;
                end
            end
            StGrant: begin
                // A normal release outranks a watchdog expiry on the same cycle.
                if (release_grant) begin
                    state_d = StIdle;
                    vld_d   = 1'b0;
                end else if (expire) begin
                    state_d   = StIdle;
                    vld_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            code_q    <= '0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            code_q    <= code_d;
            vld_q     <= vld_d;
            timeout_q <= timeout_d;
        end
    end

    onehot_dec_2_4 u_dec (
        .code_i   (code_q),
        .onehot_o (dec)
    );

    assign gnt_o      = dec & {NREQ{vld_q}};
    assign gnt_code_o = code_q;
    assign gnt_vld_o  = vld_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; covers the watchdog when GRANT_TIMEOUT_EN is defined.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_code;
    logic       gnt_vld;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(
        .TIMEOUT (4),
        .TO_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .done_i     (done),
        .gnt_o      (gnt),
        .gnt_code_o (gnt_code),
        .gnt_vld_o  (gnt_vld),
        .timeout_o  (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] exp_gnt,
                              input logic [1:0] exp_code, input logic exp_to);
        chk({tag, ".gnt"}, gnt, exp_gnt);
        chk({tag, ".vld"}, {3'b0, gnt_vld}, {3'b0, |exp_gnt});
        if (exp_gnt != 4'b0000) chk({tag, ".code"}, {2'b0, gnt_code}, {2'b0, exp_code});
        chk({tag, ".timeout"}, {3'b0, timeout}, {3'b0, exp_to});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        #12;
        expect_gnt("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset.code", {2'b0, gnt_code}, 4'd0);
        rst_n = 1'b1;
        tick(); expect_gnt("first", 4'b0001, 2'd0, 1'b0);

        // Round robin with done each grant: 0,1,2,3,0 with a bubble between.
        done = 1'b1; tick(); done = 1'b0; expect_gnt("bub0", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("rr1", 4'b0010, 2'd1, 1'b0);
        done = 1'b1; tick(); done = 1'b0; expect_gnt("bub1", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("rr2", 4'b0100, 2'd2, 1'b0);
        done = 1'b1; tick(); done = 1'b0; expect_gnt("bub2", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("rr3", 4'b1000, 2'd3, 1'b0);
        done = 1'b1; tick(); done = 1'b0; expect_gnt("bub3", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("rr0", 4'b0001, 2'd0, 1'b0);

        // Move ptr to 2, then req=0011 must wrap 2->3->0.
        done = 1'b1; tick(); done = 1'b0; expect_gnt("bub4", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("own1", 4'b0010, 2'd1, 1'b0);
        done = 1'b1; req = 4'b0011; tick(); done = 1'b0;
        expect_gnt("bub5", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("wrap", 4'b0001, 2'd0, 1'b0);

        // ptr=1: grant 1, non-owner churn, then owner drops req without done.
        done = 1'b1; tick(); done = 1'b0; expect_gnt("bub6", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("grant1", 4'b0010, 2'd1, 1'b0);
        req = 4'b1011; tick(); expect_gnt("nonowner", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000; tick(); expect_gnt("drop", 4'b0000, 2'd0, 1'b0);
        done = 1'b1; tick(); done = 1'b0; expect_gnt("done_idle", 4'b0000, 2'd0, 1'b0);
        tick(); expect_gnt("still_idle", 4'b0000, 2'd0, 1'b0);

        // ptr=2: grant 2, then async reset mid-grant.
        req = 4'b0100; tick(); expect_gnt("grant2", 4'b0100, 2'd2, 1'b0);
        #3 rst_n = 1'b0;
        #1 expect_gnt("async_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1111;
        tick(); expect_gnt("in_rst", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick(); expect_gnt("post_rst", 4'b0001, 2'd0, 1'b0);

`ifdef GRANT_TIMEOUT_EN
        // TIMEOUT=4: held four cycles, then forced release with a one-cycle pulse.
        for (int i = 1; i < 4; i++) begin
            tick(); expect_gnt("hold", 4'b0001, 2'd0, 1'b0);
        end
        tick(); expect_gnt("forced", 4'b0000, 2'd0, 1'b1);
        tick(); expect_gnt("regrant", 4'b0010, 2'd1, 1'b0);
        for (int i = 1; i < 3; i++) begin
            tick(); expect_gnt("hold1", 4'b0010, 2'd1, 1'b0);
        end
        done = 1'b1; tick(); done = 1'b0;
        expect_gnt("done_at_limit", 4'b0000, 2'd0, 1'b0);
`else
        for (int i = 1; i < 20; i++) begin
            tick(); expect_gnt("hold", 4'b0001, 2'd0, 1'b0);
        end
        done = 1'b1; tick(); done = 1'b0;
        expect_gnt("late_done", 4'b0000, 2'd0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
